// File: rtl/matmul_pkg.sv
// Shared types and helpers for the complex matrix-multiply sequencer.
//   state_t     : sequencer states
//   dl_entry_t  : one delay-line slot {valid, first, last, idx}
//   LAT_DEFAULT : default address-to-accumulator latency in ce ticks
//   addr_w()    : address width for a DIM x DIM matrix
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LAT_DEFAULT = 3;

  // idx is sized for the largest matrix we expect to sequence (256x256);
  // smaller instances simply carry zeros in the upper bits.
  localparam int IDX_W = 16;

  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [IDX_W-1:0] idx;
  } dl_entry_t;

  // Bits needed to address DIM*DIM elements; a 1x1 matrix still gets one bit.
  function automatic int addr_w(input int dim);
    return (dim <= 1) ? 1 : $clog2(dim * dim);
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register that carries per-issue control info alongside
// the datapath latency.
//   clk_fast : clock
//   rst      : synchronous active-high clear of every stage
//   i_en     : shift enable (one stage per enabled cycle)
//   i_din    : word entering stage 0
//   o_tail   : registered output of the last stage
module ctrl_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk_fast,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_tail
);

  // w_tap[n] feeds stage n; w_tap[DEPTH] is the tail.
  logic [DEPTH:0][WIDTH-1:0] w_tap;

  assign w_tap[0] = i_din;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] r_q;

      always_ff @(posedge clk_fast) begin
        if (rst) begin
          r_q <= '0;
        end else if (i_en) begin
          r_q <= w_tap[gi];
        end
      end

      assign w_tap[gi+1] = r_q;
    end
  endgenerate

  assign o_tail = w_tap[DEPTH];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the DIM x DIM complex matrix-multiply datapath. A start
// pulse walks (i,j,k) row-major, issuing M1/M2 read addresses one per ce
// tick, and drives the accumulator clear/enable and per-element flag after
// LAT ticks of datapath latency.
//   clk_fast     : clock
//   rst          : synchronous active-high reset (aborts a run, no done)
//   ce           : advance enable
//   start        : run request, sampled only in IDLE
//   read_addr_M1 : {i,k}      read_addr_M2 : {k,j}
//   acc_clr      : accumulator loads instead of adds (first term)
//   acc_en       : accumulator captures this cycle
//   flag_out     : accumulator holds final value of element out_addr
//   out_addr     : element index {i,j} aligned with acc_en/flag_out
//   busy         : not in IDLE      done : one-cycle completion pulse
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DIM    = 32,
  parameter int LAT    = LAT_DEFAULT,
  parameter int ADDR_W = addr_w(DIM)
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  output logic [ADDR_W-1:0] read_addr_M1,
  output logic [ADDR_W-1:0] read_addr_M2,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              flag_out,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIM - 1);
  localparam int              DRN_W   = $clog2(LAT + 1);
  localparam logic [DRN_W-1:0] DRN_MAX = DRN_W'(LAT - 1);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_i, r_j, r_k;
  logic [DRN_W-1:0]  r_drn;
  logic [ADDR_W-1:0] r_addr_m1, r_addr_m2;
  logic [ADDR_W-1:0] w_addr_m1, w_addr_m2, w_idx;
  logic              w_issue, w_drain_tick, w_finish, w_last_issue;
  dl_entry_t         w_push, w_tail;
  logic              w_unused_tail;

  // Row-major addresses are plain concatenations of the counters; a 1x1
  // matrix has a single element at address 0.
  generate
    if (DIM == 1) begin : g_addr_one
      assign w_addr_m1 = '0;
      assign w_addr_m2 = '0;
      assign w_idx     = '0;
    end else begin : g_addr_cat
      assign w_addr_m1 = {r_i, r_k};
      assign w_addr_m2 = {r_k, r_j};
      assign w_idx     = {r_i, r_j};
    end
  endgenerate

  assign w_last_issue = (r_i == CNT_MAX) && (r_j == CNT_MAX) && (r_k == CNT_MAX);

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_drain_tick = 1'b0;
    w_finish     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = RUN;
      end
      RUN: begin
        if (ce) begin
          w_issue = 1'b1;
          if (w_last_issue) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (ce) begin
          w_drain_tick = 1'b1;
          if (r_drn == DRN_MAX) w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_finish     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_drn     <= '0;
      r_addr_m1 <= '0;
      r_addr_m2 <= '0;
    end else begin
      if (w_issue) begin
        r_addr_m1 <= w_addr_m1;
        r_addr_m2 <= w_addr_m2;
        if (r_k == CNT_MAX) begin
          r_k <= '0;
          if (r_j == CNT_MAX) begin
            r_j <= '0;
            r_i <= (r_i == CNT_MAX) ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
      if (w_drain_tick) r_drn <= r_drn + 1'b1;
      // Final-issue addresses stay put through DRAIN and clear on the way
      // back to IDLE.
      if (w_finish) begin
        r_drn     <= '0;
        r_addr_m1 <= '0;
        r_addr_m2 <= '0;
      end
    end
  end

  // Outside RUN the line is fed invalid slots, which is what drains it.
  always_comb begin
    w_push = '0;
    if (w_issue) begin
      w_push.valid = 1'b1;
      w_push.first = (r_k == '0);
      w_push.last  = (r_k == CNT_MAX);
      w_push.idx   = IDX_W'(w_idx);
    end
  end

  ctrl_delay_line #(
    .WIDTH($bits(dl_entry_t)),
    .DEPTH(LAT)
  ) u_delay (
    .clk_fast(clk_fast),
    .rst     (rst),
    .i_en    (ce),
    .i_din   (w_push),
    .o_tail  (w_tail)
  );

  assign read_addr_M1 = r_addr_m1;
  assign read_addr_M2 = r_addr_m2;
  assign acc_en       = w_tail.valid & ce;
  assign acc_clr      = w_tail.valid & w_tail.first & ce;
  assign flag_out     = w_tail.valid & w_tail.last & ce;
  assign out_addr     = w_tail.idx[ADDR_W-1:0];

  // Upper idx bits only matter for larger matrices.
  assign w_unused_tail = ^w_tail;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
module tb_matmul_seq_ctrl;

  localparam int D = 4;
  localparam int L = 3;
  localparam int N = D * D * D;

  logic clk_fast = 1'b0;
  always #5 clk_fast = ~clk_fast;

  // DIM=4, LAT=3 instance
  logic       rst = 1'b1, ce = 1'b0, start = 1'b0;
  logic [3:0] a1, a2, oa;
  logic       clr, en, flg, busy, done;

  matmul_seq_ctrl #(.DIM(D), .LAT(L)) u_dut (
    .clk_fast    (clk_fast),
    .rst         (rst),
    .ce          (ce),
    .start       (start),
    .read_addr_M1(a1),
    .read_addr_M2(a2),
    .acc_clr     (clr),
    .acc_en      (en),
    .flag_out    (flg),
    .out_addr    (oa),
    .busy        (busy),
    .done        (done)
  );

  // DIM=1, LAT=1 instance
  logic       rst1 = 1'b1, ce1 = 1'b0, start1 = 1'b0;
  logic [0:0] b_a1, b_a2, b_oa;
  logic       b_clr, b_en, b_flg, b_busy, b_done;

  matmul_seq_ctrl #(.DIM(1), .LAT(1)) u_dut1 (
    .clk_fast    (clk_fast),
    .rst         (rst1),
    .ce          (ce1),
    .start       (start1),
    .read_addr_M1(b_a1),
    .read_addr_M2(b_a2),
    .acc_clr     (b_clr),
    .acc_en      (b_en),
    .flag_out    (b_flg),
    .out_addr    (b_oa),
    .busy        (b_busy),
    .done        (b_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is DIM^3 issue ticks then LAT drain ticks, then
  // one completion cycle. Issue n reads M1[i][k], M2[k][j] with
  // n = (i*D + j)*D + k; accumulator event e happens LAT ticks after issue e.
  int m_phase = 0;  // 0 idle, 1 active, 2 completing
  int m_t     = 0;  // ce ticks consumed since the run began
  int exp_a1  = 0;
  int exp_a2  = 0;

  always @(posedge clk_fast) begin
    if (rst) begin
      m_phase <= 0;
      m_t     <= 0;
      exp_a1  <= 0;
      exp_a2  <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_phase <= 1;
             m_t     <= 0;
           end
        1: if (ce) begin
             if (m_t < N) begin
               exp_a1 <= (m_t / (D * D)) * D + (m_t % D);
               exp_a2 <= (m_t % D) * D + ((m_t / D) % D);
             end
             m_t <= m_t + 1;
             if (m_t + 1 == N + L) m_phase <= 2;
           end
        default: begin
          m_phase <= 0;
          exp_a1  <= 0;
          exp_a2  <= 0;
        end
      endcase
    end
  end

  logic chk_en = 1'b0;
  int   tot_flags = 0, tot_dones = 0, tot_busy = 0;

  always @(negedge clk_fast) begin
    int e;
    if (chk_en) begin
      e = m_t - L;
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == 2);
      check("addr_m1", a1, exp_a1);
      check("addr_m2", a2, exp_a2);
      if (m_phase == 1 && ce && e >= 0 && e < N) begin
        check("acc_en", en, 1);
        check("acc_clr", clr, (e % D) == 0);
        check("flag_out", flg, (e % D) == D - 1);
        check("out_addr", oa, e / D);
      end else begin
        check("acc_en_off", en, 0);
        check("acc_clr_off", clr, 0);
        check("flag_out_off", flg, 0);
      end
      if (flg) $display("element out_addr=%0d finished at %0t", oa, $time);
      if (flg) tot_flags++;
      if (done) tot_dones++;
      if (busy) tot_busy++;
    end
  end

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  function automatic logic pick_ce(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return cyc[0];
    return $urandom_range(0, 3) != 0;
  endfunction

  // mode 0: ce always 1; mode 1: ce every other cycle;
  // mode 2: random ce with stray start pulses during the run.
  task automatic do_run(input string name, input int mode);
    int cyc, f0, d0, b0;
    f0 = tot_flags; d0 = tot_dones; b0 = tot_busy;
    start = 1'b1;
    ce    = pick_ce(mode, 0);
    tick();
    start = 1'b0;
    cyc = 0;
    while (m_phase != 0 && cyc < 2000) begin
      ce    = pick_ce(mode, cyc + 1);
      start = (mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    check({name, "_finished"}, cyc < 2000, 1);
    check({name, "_flags"}, tot_flags - f0, D * D);
    check({name, "_dones"}, tot_dones - d0, 1);
    if (mode == 0) check({name, "_busy_cycles"}, tot_busy - b0, N + L + 1);
    $display("run %s: flags=%0d dones=%0d busy_cycles=%0d", name,
             tot_flags - f0, tot_dones - d0, tot_busy - b0);
  endtask

  initial begin
    int cyc, f0, d0;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ce  = 1'b1;
    repeat (3) tick();

    do_run("ce_const", 0);
    repeat (2) tick();
    do_run("ce_half", 1);
    repeat (2) tick();
    do_run("ce_rand_a", 2);
    do_run("ce_rand_b", 2);

    // abort in the middle of a run
    f0 = tot_flags; d0 = tot_dones;
    start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (m_t < 20 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("abort_reached_issue20", m_t, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    f0 = tot_flags;
    repeat (20) tick();
    check("abort_no_flags", tot_flags - f0, 0);
    check("abort_no_done", tot_dones - d0, 0);
    do_run("restart", 0);

    // DIM=1, LAT=1 directed run
    ce1 = 1'b1; rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    check("d1_idle_busy", b_busy, 0);
    check("d1_idle_en", b_en, 0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("d1_run_busy", b_busy, 1);
    check("d1_run_en", b_en, 0);
    tick();
    check("d1_addr_m1", b_a1, 0);
    check("d1_addr_m2", b_a2, 0);
    check("d1_acc_en", b_en, 1);
    check("d1_acc_clr", b_clr, 1);
    check("d1_flag", b_flg, 1);
    check("d1_out_addr", b_oa, 0);
    check("d1_done_early", b_done, 0);
    tick();
    check("d1_done", b_done, 1);
    check("d1_done_en", b_en, 0);
    tick();
    check("d1_done_gone", b_done, 0);
    check("d1_back_idle", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
